// File: rtl/regfile_read_arbiter.sv
// Shares one combinational register-file read port among NREQ requesters.
// Define REGFILE_ARB_RR_EN for round-robin; otherwise lowest index wins.
module regfile_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rf_rd_addr,
    input  logic [DATA_W-1:0]      rf_rd_data,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [ADDR_W-1:0] win_addr;
    int                j;

`ifdef REGFILE_ARB_RR_EN
    logic [IDW-1:0]    ptr_q, ptr_d;
`endif

    // Search order starts at the pointer (or at 0) and wraps mod NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef REGFILE_ARB_RR_EN
            j = (int'(ptr_q) + k) % NREQ;
`else
            j = k;
`endif
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
                win_addr  = req_addr[j*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        addr_d      = addr_q;
        owner_d     = owner_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef REGFILE_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_READ;
                    gnt_d   = NREQ'(1) << win_idx;
                    addr_d  = win_addr;
                    owner_d = win_idx;
`ifdef REGFILE_ARB_RR_EN
                    ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0
                                                          : win_idx + 1'b1;
`endif
                end
            end
            // addr_q is the port address; clearing it idles the port.
            S_READ: begin
                rsp_data_d  = rf_rd_data;
                rsp_id_d    = owner_q;
                rsp_valid_d = 1'b1;
                addr_d      = '0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            addr_q      <= '0;
            owner_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef REGFILE_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef REGFILE_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign rf_rd_addr = addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a small register-file model.
// Round-robin cases run when REGFILE_ARB_RR_EN is defined, else fixed-priority.
module tb_regfile_read_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [3:0]  gnt;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_ready;
    logic        busy;

    int total;
    int bad;

    regfile_read_arbiter #(
        .NREQ(4),
        .ADDR_W(5),
        .DATA_W(64)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R5 holds DEAD_BEEF; every other register returns C0DE0000 + index.
    always_comb begin
        if (rf_rd_addr == 5'd5)
            rf_rd_data = 64'h0000_0000_DEAD_BEEF;
        else
            rf_rd_data = {32'hC0DE_0000, 27'h0, rf_rd_addr};
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        req       = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_addr", 64'(rf_rd_addr), 64'h0);
        chk("rst_id", 64'(rsp_id), 64'h0);
        chk("rst_data", rsp_data, 64'h0);
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a read
        req = 4'b0001;
        set_addr(0, 5'd3);
        tick();
        chk("abort_pre_busy", 64'(busy), 64'h1);
        reset_n = 1'b0;
        req     = '0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_gnt", 64'(gnt), 64'h0);
        chk("abort_addr", 64'(rf_rd_addr), 64'h0);
        tick();
        chk("abort_valid", 64'(rsp_valid), 64'h0);
        chk("abort_data", rsp_data, 64'h0);
        reset_n = 1'b1;
        tick();
        chk("abort_idle", 64'(rsp_valid), 64'h0);

        // Single read of R5
        req = 4'b0001;
        set_addr(0, 5'd5);
        tick();
        chk("single_gnt", 64'(gnt), 64'h1);
        chk("single_rfaddr", 64'(rf_rd_addr), 64'd5);
        chk("single_busy", 64'(busy), 64'h1);
        req = '0;
        tick();
        chk("single_gnt_pulse", 64'(gnt), 64'h0);
        chk("single_valid", 64'(rsp_valid), 64'h1);
        chk("single_id", 64'(rsp_id), 64'h0);
        chk("single_data", rsp_data, 64'h0000_0000_DEAD_BEEF);
        chk("single_rfaddr0", 64'(rf_rd_addr), 64'h0);
        rsp_ready = 1'b1;
        tick();
        chk("single_done_v", 64'(rsp_valid), 64'h0);
        chk("single_done_b", 64'(busy), 64'h0);

        // Backpressure
        rsp_ready = 1'b0;
        req = 4'b0001;
        set_addr(0, 5'd7);
        tick();
        req = '0;
        tick();
        req = 4'b0010;
        set_addr(1, 5'd9);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_data", rsp_data, 64'hC0DE_0000_0000_0007);
            chk("bp_gnt", 64'(gnt), 64'h0);
            chk("bp_busy", 64'(busy), 64'h1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_v", 64'(rsp_valid), 64'h0);
        chk("bp_release_g", 64'(gnt), 64'h0);
        tick();
        chk("bp_next_gnt", 64'(gnt), 64'h2);
        chk("bp_next_addr", 64'(rf_rd_addr), 64'd9);
        req = '0;
        tick();
        chk("bp_next_id", 64'(rsp_id), 64'h1);
        chk("bp_next_data", rsp_data, 64'hC0DE_0000_0000_0009);
        tick();

`ifdef REGFILE_ARB_RR_EN
        // Round-robin contention from a fresh pointer
        do_reset();
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(10 + i));
        for (int g = 0; g < 5; g++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (g % 4);
            tick();
            chk("rr_gnt", 64'(gnt), 64'(eg));
            if (g == 4) req = '0;
            tick();
            chk("rr_gap1", 64'(gnt), 64'h0);
            chk("rr_id", 64'(rsp_id), 64'(g % 4));
            tick();
            chk("rr_gap2", 64'(gnt), 64'h0);
        end

        // Wrap: pointer moves to 3 after a grant to 2
        req = 4'b0100;
        set_addr(2, 5'd4);
        tick();
        chk("wrap_pre_gnt", 64'(gnt), 64'h4);
        req = '0;
        tick();
        tick();
        req = 4'b1001;
        set_addr(3, 5'd31);
        set_addr(0, 5'd0);
        tick();
        chk("wrap_gnt3", 64'(gnt), 64'h8);
        chk("wrap_addr31", 64'(rf_rd_addr), 64'd31);
        req = 4'b0001;
        tick();
        chk("wrap_id3", 64'(rsp_id), 64'h3);
        chk("wrap_data31", rsp_data, 64'hC0DE_0000_0000_001F);
        tick();
        tick();
        chk("wrap_gnt0", 64'(gnt), 64'h1);
        req = '0;
        tick();
        chk("wrap_id0", 64'(rsp_id), 64'h0);
        tick();
`else
        // Fixed priority: requester 1 beats 2 while it keeps asking
        rsp_ready = 1'b1;
        req = 4'b0110;
        set_addr(1, 5'd1);
        set_addr(2, 5'd2);
        tick();
        chk("fp_gnt1a", 64'(gnt), 64'h2);
        tick();
        chk("fp_id1a", 64'(rsp_id), 64'h1);
        tick();
        chk("fp_idle", 64'(gnt), 64'h0);
        tick();
        chk("fp_gnt1b", 64'(gnt), 64'h2);
        req = 4'b0100;
        tick();
        tick();
        tick();
        chk("fp_gnt2", 64'(gnt), 64'h4);
        chk("fp_addr2", 64'(rf_rd_addr), 64'd2);
        req = '0;
        tick();
        chk("fp_id2", 64'(rsp_id), 64'h2);
        chk("fp_data2", rsp_data, 64'hC0DE_0000_0000_0002);
        tick();
        // Fixed priority ignores history: 0 wins over 3
        req = 4'b1001;
        set_addr(3, 5'd31);
        set_addr(0, 5'd0);
        tick();
        chk("fp_gnt0", 64'(gnt), 64'h1);
        req = 4'b1000;
        tick();
        tick();
        tick();
        chk("fp_gnt3", 64'(gnt), 64'h8);
        chk("fp_addr31", 64'(rf_rd_addr), 64'd31);
        req = '0;
        tick();
        chk("fp_data31", rsp_data, 64'hC0DE_0000_0000_001F);
        tick();
`endif
        chk("end_busy", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
